pri_dec_3_8_hold: RTL and testbench

//  Registered 3-to-8 decoder with a hold timer. It sits on the output side of the
//  8-to-3 priority encoder (inputs i / y / idle) and turns the encoded winner back

---
 rtl/pri_dec_3_8_hold_if.sv | 58 +++++
 rtl/pri_dec_3_8_hold.sv | 136 +++++++++++++
 tb/tb_pri_dec_3_8_hold.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pri_dec_3_8_hold_if.sv
// ----------------------------------------------------------------------------
// pri_dec_3_8_hold_if
// Bundles the code/valid/ready handshake coming from the upstream priority
// encoder together with the decoded grant outputs of pri_dec_3_8_hold.
//
// Parameters
//   N  number of one-hot grant lines
//   W  width of the encoded index
//
// Signals
//   code_in    encoded index from the priority encoder
//   idle_in    encoder saw no active request; code_in carries no meaning
//   in_valid   code_in/idle_in are valid this cycle
//   in_ready   decoder can accept a code this cycle
//   dec_out    registered one-hot grant
//   out_valid  high while dec_out holds a grant
//   busy       high while a grant or its trailing gap cycle is in progress
//   err        one-cycle pulse when an accepted code has no matching grant line
//
// Modports
//   master  upstream side: drives the code, observes ready and the grant
//   slave   decoder side
// ----------------------------------------------------------------------------
interface pri_dec_3_8_hold_if #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
);
    logic [W-1:0] code_in;
    logic         idle_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dec_out;
    logic         out_valid;
    logic         busy;
    logic         err;

    modport master (
        output code_in,
        output idle_in,
        output in_valid,
        input  in_ready,
        input  dec_out,
        input  out_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  code_in,
        input  idle_in,
        input  in_valid,
        output in_ready,
        output dec_out,
        output out_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/pri_dec_3_8_hold.sv
// ----------------------------------------------------------------------------
// pri_dec_3_8_hold
// Registered W-to-N decoder with a hold timer, placed behind an N-to-W
// priority encoder. Each accepted code becomes a one-hot grant that is held
// for HOLD cycles, followed by one all-zero gap cycle (break-before-make)
// before the next code can be accepted. in_ready throttles the encoder while
// a grant or gap is in progress.
//
// Parameters
//   N     number of one-hot outputs (2..8)
//   W     code width, $clog2(N), at least 1
//   HOLD  grant duration in cycles (1..255)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; drops any grant immediately
//   bus    slave side of pri_dec_3_8_hold_if (handshake + grant outputs)
// ----------------------------------------------------------------------------
module pri_dec_3_8_hold #(
    parameter int N    = 8,
    parameter int W    = (N > 1) ? $clog2(N) : 1,
    parameter int HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pri_dec_3_8_hold_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    // The counter is loaded with HOLD-1 and counts down to zero, so the
    // grant stays up for exactly HOLD cycles and the counter never wraps.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    state_t       state_q;
    state_t       state_d;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic [N-1:0] dec_q;
    logic [N-1:0] dec_d;
    logic         valid_q;
    logic         valid_d;
    logic         err_q;
    logic         err_d;
    logic         ready;
    logic         accept;
    logic         in_range;

    // Ready depends only on the state and reset, never on in_valid, so the
    // upstream encoder sees no combinational loop through the handshake.
    assign ready  = (state_q == ST_IDLE) && rst_n;
    assign accept = bus.in_valid && ready;

    // When N fills the whole code space every code is legal; otherwise codes
    // at or above N have no grant line and raise err instead.
    generate
        if (N == (1 << W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [W-1:0] N_CODE = W'(N);
            assign in_range = (bus.code_in < N_CODE);
        end
    endgenerate

    // State register and all registered outputs. Reset clears the grant
    // asynchronously, so a reset mid-grant skips the gap cycle entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            dec_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. err defaults low so it can only ever pulse for the
    // single cycle after an out-of-range accept. code_in is only looked at
    // when a code is actually accepted, so X/Z while in_valid=0 is harmless.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !bus.idle_in) begin
                    if (in_range) begin
                        dec_d   = N'(1) << bus.code_in;
                        valid_d = 1'b1;
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    dec_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                dec_d   = '0;
                valid_d = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.dec_out   = dec_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == ST_HOLD) || (state_q == ST_GAP);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pri_dec_3_8_hold.sv
// ----------------------------------------------------------------------------
// tb_pri_dec_3_8_hold
// Drives two decoder instances: dut_a (N=8, HOLD=4) and dut_b (N=6, HOLD=1,
// so codes 6 and 7 are out of range). Only one instance is stimulated at a
// time; the other sits with in_valid=0.
//
// The reference model describes each grant as a timeline: an accept seen
// after edge k produces the grant over cycles k..k+HOLD-1, a zero gap cycle
// at k+HOLD, and readiness again from k+HOLD+1. Every cycle the DUT outputs
// are compared against what that timeline predicts.
// ----------------------------------------------------------------------------
module tb_pri_dec_3_8_hold;

    localparam int N_A    = 8;
    localparam int W_A    = 3;
    localparam int HOLD_A = 4;
    localparam int N_B    = 6;
    localparam int W_B    = 3;
    localparam int HOLD_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pri_dec_3_8_hold_if #(.N(N_A), .W(W_A)) ifa ();
    pri_dec_3_8_hold_if #(.N(N_B), .W(W_B)) ifb ();

    pri_dec_3_8_hold #(.N(N_A), .W(W_A), .HOLD(HOLD_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    pri_dec_3_8_hold #(.N(N_B), .W(W_B), .HOLD(HOLD_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    // Active instance and its parameters as the model sees them.
    int act;
    int m_n;
    int m_hold;

    // Timeline model of the active instance.
    int cyc;
    int grant_from;
    int grant_to;
    int grant_code;
    int ready_from;
    int err_at;

    // Copy of what is currently being driven on the active interface.
    bit         cur_vld;
    bit         cur_idle;
    logic [2:0] cur_code;

    bit last_dut_acc;
    int acc_log[$];

    // Loop scratch for the random phases.
    bit         r_vld;
    bit         r_idle;
    logic [2:0] r_code;
    int         b2b_size;

    function automatic logic [7:0] obsDec();
        return (act != 0) ? {2'b00, ifb.dec_out} : ifa.dec_out;
    endfunction

    function automatic logic obsValid();
        return (act != 0) ? ifb.out_valid : ifa.out_valid;
    endfunction

    function automatic logic obsReady();
        return (act != 0) ? ifb.in_ready : ifa.in_ready;
    endfunction

    function automatic logic obsBusy();
        return (act != 0) ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic obsErr();
        return (act != 0) ? ifb.err : ifa.err;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h",
                   tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit vld, input bit idle, input logic [2:0] code);
        cur_vld  = vld;
        cur_idle = idle;
        cur_code = code;
        if (act != 0) begin
            ifb.in_valid = vld;
            ifb.idle_in  = idle;
            ifb.code_in  = code;
        end else begin
            ifa.in_valid = vld;
            ifa.idle_in  = idle;
            ifa.code_in  = code;
        end
    endtask

    task automatic modelClear();
        grant_from = 0;
        grant_to   = -1;
        grant_code = 0;
        ready_from = 0;
        err_at     = -1;
    endtask

    // An accept observed after the edge that starts cycle cyc.
    task automatic modelAccept();
        if (!cur_idle) begin
            if (int'(cur_code) >= m_n) begin
                err_at = cyc;
            end else begin
                grant_code = int'(cur_code);
                grant_from = cyc;
                grant_to   = cyc + m_hold - 1;
                ready_from = cyc + m_hold + 1;
            end
        end
    endtask

    task automatic checkAll();
        logic [31:0] exp_dec;
        exp_dec = (cyc >= grant_from && cyc <= grant_to) ? (32'd1 << grant_code) : 32'd0;
        checkOutput("dec_out",   32'(obsDec()),   exp_dec);
        checkOutput("out_valid", 32'(obsValid()), 32'(exp_dec != 32'd0));
        checkOutput("in_ready",  32'(obsReady()), 32'(rst_n && (cyc >= ready_from)));
        checkOutput("busy",      32'(obsBusy()),  32'(rst_n && (cyc < ready_from)));
        checkOutput("err",       32'(obsErr()),   32'(cyc == err_at));
    endtask

    // Called away from the rising edge with inputs already settled; advances
    // one clock and checks the outputs at the following falling edge.
    task automatic stepCycle();
        bit model_acc;
        bit dut_acc;
        model_acc = cur_vld && rst_n && (cyc >= ready_from);
        dut_acc   = cur_vld && (obsReady() === 1'b1);
        @(posedge clk);
        cyc++;
        last_dut_acc = dut_acc;
        if (dut_acc) acc_log.push_back(cyc);
        if (model_acc) modelAccept();
        @(negedge clk);
        checkAll();
    endtask

    // Holds a request until the DUT takes it, within a cycle budget.
    task automatic sendCode(input bit idle, input logic [2:0] code, input int budget);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        applyStimulus(1'b1, idle, code);
        while (!done && n < budget) begin
            stepCycle();
            done = last_dut_acc;
            n++;
        end
        checks++;
        assert (done)
        else begin
            errors++;
            $error("[TB] FAIL accept_timeout code %0d: observed not-accepted expected accepted within %0d cycles",
                   code, budget);
        end
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 1'b0, 3'bxxx);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        ifa.in_valid = 1'b0;
        ifa.idle_in  = 1'b0;
        ifa.code_in  = 3'd0;
        ifb.in_valid = 1'b0;
        ifb.idle_in  = 1'b0;
        ifb.code_in  = 3'd0;
        act    = 0;
        m_n    = N_A;
        m_hold = HOLD_A;
        cyc    = 0;
        modelClear();
        $display("[TB] start");

        // Reset held with a pending request: nothing may be granted or accepted.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd3);
        stepCycle();
        stepCycle();
        checkOutput("rst_dec", 32'(ifa.dec_out), 32'd0);
        checkOutput("rst_ready", 32'(ifa.in_ready), 32'd0);
        checkOutput("rst_err", 32'(ifa.err), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'bxxx);
        #2 rst_n = 1'b1;
        #1 checkOutput("rst_release_ready", 32'(ifa.in_ready), 32'd1);
        stepCycle();

        // Basic grant of code 5 for HOLD_A cycles, then one gap cycle.
        sendCode(1'b0, 3'd5, 10);
        checkOutput("basic_grant", 32'(ifa.dec_out), 32'h20);
        idleCycles(HOLD_A + 2);
        checkOutput("basic_ready_after", 32'(ifa.in_ready), 32'd1);

        // Idle code: nothing granted, decoder stays ready.
        sendCode(1'b1, 3'd0, 10);
        idleCycles(2);
        checkOutput("idle_dec", 32'(ifa.dec_out), 32'd0);
        checkOutput("idle_busy", 32'(ifa.busy), 32'd0);

        // Back-to-back with in_valid held high.
        acc_log.delete();
        sendCode(1'b0, 3'd7, 20);
        checkOutput("b2b_grant7", 32'(ifa.dec_out), 32'h80);
        sendCode(1'b0, 3'd6, 20);
        checkOutput("b2b_grant6", 32'(ifa.dec_out), 32'h40);
        sendCode(1'b0, 3'd4, 20);
        checkOutput("b2b_grant4", 32'(ifa.dec_out), 32'h10);
        idleCycles(HOLD_A + 2);
        b2b_size = acc_log.size();
        checkOutput("b2b_accepts", 32'(b2b_size), 32'd3);
        if (b2b_size >= 3) begin
            checkOutput("b2b_spacing1", 32'(acc_log[1] - acc_log[0]), 32'(HOLD_A + 2));
            checkOutput("b2b_spacing2", 32'(acc_log[2] - acc_log[1]), 32'(HOLD_A + 2));
        end

        // Reset in the second cycle of a code-3 grant drops it at once.
        sendCode(1'b0, 3'd3, 10);
        applyStimulus(1'b0, 1'b0, 3'bxxx);
        stepCycle();
        checkOutput("mid_pre_reset", 32'(ifa.dec_out), 32'h08);
        #2 rst_n = 1'b0;
        #1 checkOutput("mid_reset_dec", 32'(ifa.dec_out), 32'd0);
        checkOutput("mid_reset_valid", 32'(ifa.out_valid), 32'd0);
        modelClear();
        @(negedge clk);
        stepCycle();
        #2 rst_n = 1'b1;
        #1 checkOutput("mid_release_ready", 32'(ifa.in_ready), 32'd1);
        stepCycle();

        // Random traffic on dut_a.
        for (int i = 0; i < 150; i++) begin
            r_vld  = ($urandom_range(0, 9) < 7);
            r_idle = ($urandom_range(0, 7) == 0);
            r_code = 3'($urandom_range(0, 7));
            if (!r_vld && $urandom_range(0, 3) == 0) r_code = 3'bxxx;
            applyStimulus(r_vld, r_idle, r_code);
            stepCycle();
        end
        idleCycles(HOLD_A + 3);

        // Switch to dut_b: N=6, HOLD=1, so codes 6 and 7 are out of range.
        act    = 1;
        m_n    = N_B;
        m_hold = HOLD_B;
        modelClear();
        applyStimulus(1'b0, 1'b0, 3'd0);
        stepCycle();

        sendCode(1'b0, 3'd6, 10);
        checkOutput("oor_err", 32'(ifb.err), 32'd1);
        checkOutput("oor_dec", 32'(ifb.dec_out), 32'd0);
        sendCode(1'b0, 3'd2, 10);
        checkOutput("oor_err_cleared", 32'(ifb.err), 32'd0);
        checkOutput("b_grant2", 32'(ifb.dec_out), 32'h04);
        idleCycles(1);
        checkOutput("b_hold1_gap", 32'(ifb.dec_out), 32'd0);
        idleCycles(2);
        sendCode(1'b0, 3'd7, 10);
        checkOutput("oor7_err", 32'(ifb.err), 32'd1);
        idleCycles(2);

        // Random traffic on dut_b, including out-of-range codes.
        for (int i = 0; i < 150; i++) begin
            r_vld  = ($urandom_range(0, 9) < 7);
            r_idle = ($urandom_range(0, 7) == 0);
            r_code = 3'($urandom_range(0, 7));
            if (!r_vld && $urandom_range(0, 3) == 0) r_code = 3'bxxx;
            applyStimulus(r_vld, r_idle, r_code);
            stepCycle();
        end
        idleCycles(HOLD_B + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion expected completion within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
